mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single 128-bit line-wide main-memory port between the instruction-side cache refill path and the data-side cache (refill and write-back). It sits between both caches' miss interfaces and the backing memory, serialising one line transaction at a time. Data side has priority, with a starvation guard for the instruction side and a timeout watchdog on the memory handshake.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between I-refill and D refill/write-back
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  grant_d,
    output logic                  timeout_err
);
    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         consec_q;
    logic [CW-1:0]         consec_d;
    logic [WW-1:0]         wdog_q;
    logic [LINE_WIDTH-1:0] i_rdata_q, d_rdata_q, mem_wdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  i_ready_q, d_ready_q, mem_req_q, mem_we_q, grant_d_q, timeout_err_q;
    logic                  pick_d;

    // D wins unless the I side has already waited through MAX_CONSEC D grants in a row
    always_comb begin
        pick_d   = d_req && !(i_req && consec_q == CW'(MAX_CONSEC));
        consec_d = (pick_d && i_req) ? consec_q + 1'b1 : '0;
    end

    // sequencer: grant in IDLE, handshake plus watchdog in WAIT, completion pulse in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            consec_q      <= '0;
            wdog_q        <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            mem_wdata_q   <= '0;
            mem_addr_q    <= '0;
            i_ready_q     <= 1'b0;
            d_ready_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            grant_d_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_req || d_req) begin
                    state_q    <= WAIT;
                    mem_req_q  <= 1'b1;
                    grant_d_q  <= pick_d;
                    mem_addr_q <= pick_d ? d_addr : i_addr;
                    mem_we_q   <= pick_d && d_we;
                    if (pick_d && d_we) mem_wdata_q <= d_wdata;
                    consec_q   <= consec_d;
                    wdog_q     <= '0;
                end
                WAIT: if (mem_ready || wdog_q == WW'(TIMEOUT - 1)) begin
                    state_q   <= DONE;
                    mem_req_q <= 1'b0;
                    if (!mem_ready) timeout_err_q <= 1'b1;
                    if (grant_d_q) begin
                        d_ready_q <= 1'b1;
                        if (!mem_we_q) d_rdata_q <= mem_ready ? mem_rdata : '0;
                    end else begin
                        i_ready_q <= 1'b1;
                        i_rdata_q <= mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    wdog_q <= wdog_q + 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdata     = i_rdata_q;
    assign i_ready     = i_ready_q;
    assign d_rdata     = d_rdata_q;
    assign d_ready     = d_ready_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant_d     = grant_d_q;
    assign timeout_err = timeout_err_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level checking of mem_arbiter against a behavioural model
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int MC = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, mem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_ready, d_ready, mem_req, mem_we, busy, grant_d, timeout_err;

    int checks = 0;
    int passed = 0;

    // model: D-grant streak while I is pending, expected held line values, sticky error
    int            streak = 0;
    logic [LW-1:0] exp_ir = '0, exp_dr = '0, exp_wdata = '0;
    logic          exp_terr = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_CONSEC(MC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One full transaction starting at an IDLE negedge with requests already driven.
    // lat = WAIT cycle in which mem_ready is given (lat > TO means never).
    task automatic do_txn(input int lat, input bit spur, input logic [LW-1:0] rd, output bit gd_obs);
        logic [AW-1:0] ea;
        logic          ew, gd, tout;
        int            cnt, exp_cnt, stray;
        gd = d_req && !(i_req && streak >= MC);
        streak = (gd && i_req) ? streak + 1 : 0;
        ea = gd ? d_addr : i_addr;
        ew = gd && d_we;
        if (ew) exp_wdata = d_wdata;
        @(negedge clk);
        gd_obs = grant_d;
        checks++; if (mem_req !== 1'b1 || busy !== 1'b1) $display("FAIL grant_start mem_req=%b busy=%b required 1/1", mem_req, busy); else passed++;
        checks++; if (grant_d !== gd) $display("FAIL grant_d got %b required %b", grant_d, gd); else passed++;
        checks++; if (mem_addr !== ea || mem_we !== ew || mem_wdata !== exp_wdata) $display("FAIL mem_cmd addr=%h we=%b wdata=%h required %h %b %h", mem_addr, mem_we, mem_wdata, ea, ew, exp_wdata); else passed++;
        if (gd) begin
            d_addr = $urandom();
            d_wdata = rnd_line();
        end else begin
            i_addr = $urandom();
        end
        cnt = 0;
        stray = 0;
        for (int c = 0; c < TO + 3 && mem_req === 1'b1; c++) begin
            cnt++;
            if (i_ready || d_ready) stray++;
            mem_ready = (cnt == lat);
            mem_rdata = (cnt == lat) ? rd : rnd_line();
            @(negedge clk);
            mem_ready = 1'b0;
        end
        tout = lat > TO;
        exp_cnt = tout ? TO : lat;
        if (!gd) exp_ir = tout ? '0 : rd;
        else if (!ew) exp_dr = tout ? '0 : rd;
        exp_terr = exp_terr | tout;
        checks++; if (cnt != exp_cnt || stray != 0) $display("FAIL mem_req_len cycles=%0d stray_ready=%0d required %0d/0", cnt, stray, exp_cnt); else passed++;
        checks++; if ({i_ready, d_ready} !== {!gd, gd}) $display("FAIL ready_pulse i=%b d=%b required %b %b", i_ready, d_ready, !gd, gd); else passed++;
        checks++; if (i_rdata !== exp_ir || d_rdata !== exp_dr) $display("FAIL rdata i=%h d=%h required %h %h", i_rdata, d_rdata, exp_ir, exp_dr); else passed++;
        checks++; if (timeout_err !== exp_terr || mem_addr !== ea || busy !== 1'b1) $display("FAIL done_state terr=%b addr=%h busy=%b required %b %h 1", timeout_err, mem_addr, busy, exp_terr, ea); else passed++;
        if (gd) d_req = 1'b0; else i_req = 1'b0;
        mem_ready = spur;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++; if (busy !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL back_idle busy=%b ir=%b dr=%b mreq=%b required 0", busy, i_ready, d_ready, mem_req); else passed++;
        checks++; if (i_rdata !== exp_ir || d_rdata !== exp_dr) $display("FAIL rdata_hold i=%h d=%h required %h %h", i_rdata, d_rdata, exp_ir, exp_dr); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({i_ready, d_ready, mem_req, mem_we, busy, grant_d, timeout_err} !== 7'b0) $display("FAIL reset_flags got %b required 0", {i_ready, d_ready, mem_req, mem_we, busy, grant_d, timeout_err}); else passed++;
        checks++; if (i_rdata !== '0 || d_rdata !== '0 || mem_wdata !== '0 || mem_addr !== '0) $display("FAIL reset_data ir=%h dr=%h wd=%h a=%h required 0", i_rdata, d_rdata, mem_wdata, mem_addr); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL reset_idle busy=%b mem_req=%b required 0", busy, mem_req); else passed++;
    endtask

    task automatic test_i_read();
        bit g;
        i_req = 1'b1;
        i_addr = 32'h0000_1000;
        do_txn(3, 1'b0, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF, g);
    endtask

    task automatic test_d_write();
        bit g;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h0001_0040;
        d_wdata = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        do_txn(1, 1'b0, rnd_line(), g);
    endtask

    task automatic test_fairness();
        bit g;
        d_we = 1'b0;
        for (int n = 0; n < 10; n++) begin
            i_req = 1'b1;
            d_req = 1'b1;
            do_txn(1, 1'b0, rnd_line(), g);
            checks++; if (g !== (n % 5 != 4)) $display("FAIL grant_order n=%0d grant_d=%b required %b", n, g, n % 5 != 4); else passed++;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_timeout();
        bit g;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h0000_2000;
        do_txn(TO + 5, 1'b0, rnd_line(), g);
        d_req = 1'b1;
        do_txn(TO, 1'b0, rnd_line(), g);
        i_req = 1'b1;
        do_txn(2, 1'b0, rnd_line(), g);
    endtask

    task automatic test_spurious();
        bit g;
        for (int n = 0; n < 3; n++) begin
            mem_ready = 1'b1;
            mem_rdata = rnd_line();
            @(negedge clk);
            checks++; if (busy !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0 || i_rdata !== exp_ir || d_rdata !== exp_dr) $display("FAIL idle_ready busy=%b ir=%b dr=%b required 0 0 0", busy, i_ready, d_ready); else passed++;
        end
        mem_ready = 1'b0;
        i_req = 1'b1;
        do_txn(2, 1'b1, rnd_line(), g);
        d_req = 1'b1;
        d_we = 1'b0;
        do_txn(1, 1'b1, rnd_line(), g);
    endtask

    task automatic test_random(input int iters);
        bit g;
        for (int n = 0; n < iters; n++) begin
            i_req = 1'($urandom_range(0, 1));
            d_req = i_req ? 1'($urandom_range(0, 1)) : 1'b1;
            i_addr = $urandom();
            d_addr = $urandom();
            d_we = 1'($urandom_range(0, 1));
            d_wdata = rnd_line();
            for (int k = 0; k < 2 && (i_req || d_req); k++)
                do_txn(int'($urandom_range(1, TO + 1)), 1'($urandom_range(0, 1)), rnd_line(), g);
        end
    endtask

    task automatic test_rst_mid();
        bit g;
        i_req = 1'b1;
        i_addr = 32'h0000_3000;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) $display("FAIL rst_pre mem_req=%b required 1", mem_req); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if ({i_ready, d_ready, mem_req, mem_we, busy, grant_d, timeout_err} !== 7'b0) $display("FAIL rst_mid_flags got %b required 0", {i_ready, d_ready, mem_req, mem_we, busy, grant_d, timeout_err}); else passed++;
        checks++; if (i_rdata !== '0 || d_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) $display("FAIL rst_mid_data ir=%h dr=%h a=%h required 0", i_rdata, d_rdata, mem_addr); else passed++;
        @(negedge clk);
        rst = 1'b0;
        streak = 0;
        exp_ir = '0;
        exp_dr = '0;
        exp_wdata = '0;
        exp_terr = 1'b0;
        i_addr = 32'h0000_3000;
        do_txn(2, 1'b0, rnd_line(), g);
    endtask

    initial begin
        i_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        mem_ready = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        mem_rdata = '0;
        test_reset();
        test_i_read();
        test_d_write();
        test_fairness();
        test_timeout();
        test_spurious();
        test_random(40);
        test_rst_mid();
        test_random(10);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
